// File: rtl/smu_trigger_ctrl.sv
// smu_trigger_ctrl: turns SMU pattern matches into a timed override enable, with a saturating count and an event record
module smu_trigger_ctrl #(
  parameter int N      = 2,
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 gated_clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic [$clog2(N)-1:0] SmuState,
  input  logic [1:0]           RegMode,
  input  logic [HOLD_W-1:0]    RegHoldCycles,
  input  logic                 RegClear,
  output logic                 ctrl_en,
  output logic                 busy,
  output logic [CNT_W-1:0]     trig_count,
  output logic                 evt_valid,
  input  logic                 evt_ack,
  output logic [$clog2(N)-1:0] evt_state,
  output logic                 evt_overflow
);
  localparam int SW = $clog2(N);
  typedef enum logic [1:0] {IDLE, HOLD, STICKY, DONE} state_t;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              oneshot_q, oneshot_d;
  logic              ctrl_en_q, ctrl_en_d;
  logic [CNT_W-1:0]  trig_count_q, trig_count_d;
  logic              evt_valid_q, evt_valid_d;
  logic [SW-1:0]     evt_state_q, evt_state_d;
  logic              evt_overflow_q, evt_overflow_d;
  logic              accept;
  // one-shot episodes swallow triggers while holding; DONE swallows them until clear
  assign accept = trigger && RegMode != 2'b00 && !RegClear && state_q != DONE
                  && !(state_q == HOLD && oneshot_q);
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    oneshot_d      = oneshot_q;
    trig_count_d   = (accept && !(&trig_count_q)) ? trig_count_q + CNT_W'(1) : trig_count_q;
    evt_valid_d    = accept ? 1'b1 : (evt_ack ? 1'b0 : evt_valid_q);
    evt_state_d    = (accept && (!evt_valid_q || evt_ack)) ? SmuState : evt_state_q;
    evt_overflow_d = evt_overflow_q | (accept && evt_valid_q && !evt_ack);
    unique case (state_q)
      IDLE: if (accept) begin
        state_d    = (RegMode == 2'b10) ? STICKY : HOLD;
        hold_cnt_d = RegHoldCycles;
        oneshot_d  = RegMode == 2'b11;
      end
      HOLD: begin
        hold_cnt_d = accept ? RegHoldCycles : hold_cnt_q - HOLD_W'(1);
        if (!accept && hold_cnt_q == '0) begin
          state_d    = oneshot_q ? DONE : IDLE;
          hold_cnt_d = '0;
        end
      end
      default: ;
    endcase
    if (RegMode == 2'b00) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end
    if (RegClear) begin
      state_d        = IDLE;
      hold_cnt_d     = '0;
      oneshot_d      = 1'b0;
      trig_count_d   = '0;
      evt_valid_d    = 1'b0;
      evt_state_d    = '0;
      evt_overflow_d = 1'b0;
    end
    ctrl_en_d = state_d == HOLD || state_d == STICKY;
  end
  always_ff @(posedge gated_clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      oneshot_q      <= 1'b0;
      ctrl_en_q      <= 1'b0;
      trig_count_q   <= '0;
      evt_valid_q    <= 1'b0;
      evt_state_q    <= '0;
      evt_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      oneshot_q      <= oneshot_d;
      ctrl_en_q      <= ctrl_en_d;
      trig_count_q   <= trig_count_d;
      evt_valid_q    <= evt_valid_d;
      evt_state_q    <= evt_state_d;
      evt_overflow_q <= evt_overflow_d;
    end
  end
  assign ctrl_en      = ctrl_en_q;
  assign busy         = state_q != IDLE;
  assign trig_count   = trig_count_q;
  assign evt_valid    = evt_valid_q;
  assign evt_state    = evt_state_q;
  assign evt_overflow = evt_overflow_q;
endmodule

// File: tb/tb_smu_trigger_ctrl.sv
// tb_smu_trigger_ctrl: directed vector table plus hand sequences for sticky, handshake, saturation and reset
module tb_smu_trigger_ctrl;
  logic        gated_clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic [0:0]  smu_state = '0;
  logic [1:0]  reg_mode = '0;
  logic [7:0]  reg_hold = '0;
  logic        reg_clear = 1'b0;
  logic        evt_ack = 1'b0;
  logic        ctrl_en, busy, evt_valid, evt_overflow;
  logic [15:0] trig_count;
  logic [0:0]  evt_state;
  logic        s_ctrl_en, s_busy, s_evt_valid, s_evt_overflow;
  logic [1:0]  s_trig_count;
  logic [0:0]  s_evt_state;
  int          checks = 0;
  int          errors = 0;
  always #5 gated_clk = ~gated_clk;
  smu_trigger_ctrl u_dut (
    .gated_clk(gated_clk), .reset(reset), .trigger(trigger), .SmuState(smu_state),
    .RegMode(reg_mode), .RegHoldCycles(reg_hold), .RegClear(reg_clear),
    .ctrl_en(ctrl_en), .busy(busy), .trig_count(trig_count), .evt_valid(evt_valid),
    .evt_ack(evt_ack), .evt_state(evt_state), .evt_overflow(evt_overflow)
  );
  smu_trigger_ctrl #(.CNT_W(2)) u_sat (
    .gated_clk(gated_clk), .reset(reset), .trigger(trigger), .SmuState(smu_state),
    .RegMode(reg_mode), .RegHoldCycles(reg_hold), .RegClear(reg_clear),
    .ctrl_en(s_ctrl_en), .busy(s_busy), .trig_count(s_trig_count), .evt_valid(s_evt_valid),
    .evt_ack(evt_ack), .evt_state(s_evt_state), .evt_overflow(s_evt_overflow)
  );
  typedef struct packed {
    logic [1:0]  mode;
    logic [7:0]  hold;
    logic        trig, st, clr, ack;
    logic        e_ctrl, e_busy;
    logic [15:0] e_cnt;
    logic        e_valid, e_st, e_ovf;
  } vec_t;
  vec_t tbl [28];
  task automatic tick();
    @(posedge gated_clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " ctrl_en"}, 32'(ctrl_en), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " trig_count"}, 32'(trig_count), 0);
    chk({tag, " evt_valid"}, 32'(evt_valid), 0);
    chk({tag, " evt_state"}, 32'(evt_state), 0);
    chk({tag, " evt_overflow"}, 32'(evt_overflow), 0);
    chk({tag, " sat trig_count"}, 32'(s_trig_count), 0);
    chk({tag, " sat ctrl_en"}, 32'(s_ctrl_en), 0);
  endtask
  task automatic clear();
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
  endtask
  initial begin
    //        mode  hold  trg   st    clr   ack   ctrl  busy  cnt  valid est  ovf
    tbl[0]  = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'd1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{2'd1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{2'd1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{2'd1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{2'd3, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{2'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{2'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{2'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{2'd2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{2'd2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{2'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{2'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{2'd0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{2'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[27] = '{2'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 28; i++) begin
      reg_mode  = tbl[i].mode;
      reg_hold  = tbl[i].hold;
      trigger   = tbl[i].trig;
      smu_state = tbl[i].st;
      reg_clear = tbl[i].clr;
      evt_ack   = tbl[i].ack;
      tick();
      chk($sformatf("row%0d ctrl_en", i), 32'(ctrl_en), 32'(tbl[i].e_ctrl));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d trig_count", i), 32'(trig_count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d evt_valid", i), 32'(evt_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d evt_state", i), 32'(evt_state), 32'(tbl[i].e_st));
      chk($sformatf("row%0d evt_overflow", i), 32'(evt_overflow), 32'(tbl[i].e_ovf));
    end
    trigger = 1'b0; evt_ack = 1'b0; reg_clear = 1'b0;
    clear();
    reg_mode = 2'd2; trigger = 1'b1; smu_state = 1'b1;
    tick();
    trigger = 1'b0;
    chk("sticky start ctrl_en", 32'(ctrl_en), 1);
    chk("sticky start trig_count", 32'(trig_count), 1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("sticky hold%0d ctrl_en", i), 32'(ctrl_en), 1);
    end
    trigger = 1'b1; smu_state = 1'b0;
    tick();
    trigger = 1'b0;
    chk("sticky retrig trig_count", 32'(trig_count), 2);
    chk("sticky retrig evt_state", 32'(evt_state), 1);
    chk("sticky retrig evt_overflow", 32'(evt_overflow), 1);
    reg_mode = 2'd0;
    tick();
    chk("disable ctrl_en", 32'(ctrl_en), 0);
    chk("disable busy", 32'(busy), 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    chk("disabled trig_count", 32'(trig_count), 2);
    clear();
    reg_mode = 2'd1; reg_hold = 8'd5; trigger = 1'b1; smu_state = 1'b0;
    tick();
    chk("hs first evt_valid", 32'(evt_valid), 1);
    chk("hs first evt_state", 32'(evt_state), 0);
    smu_state = 1'b1; evt_ack = 1'b1;
    tick();
    chk("hs ack+post evt_valid", 32'(evt_valid), 1);
    chk("hs ack+post evt_state", 32'(evt_state), 1);
    chk("hs ack+post evt_overflow", 32'(evt_overflow), 0);
    chk("hs ack+post trig_count", 32'(trig_count), 2);
    trigger = 1'b0;
    tick();
    evt_ack = 1'b0;
    chk("hs ack alone evt_valid", 32'(evt_valid), 0);
    clear();
    reg_mode = 2'd1; reg_hold = 8'd10; trigger = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    trigger = 1'b0;
    chk("sat trig_count", 32'(s_trig_count), 3);
    chk("wide trig_count", 32'(trig_count), 5);
    chk("sat mid-hold ctrl_en", 32'(s_ctrl_en), 1);
    reset = 1'b1;
    tick();
    chk_zero("reset mid-hold");
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/smu_trigger_ctrl.md
# smu_trigger_ctrl

Trigger response controller that sits directly downstream of the signal monitoring unit (SMU). It consumes the SMU `trigger` pulse and `SmuState` and turns a pattern match into a timed override enable for the signal control stage. It keeps a saturating match counter and raises a valid/ack event record for the patch management controller.

## Interface
- `N`, 2: SMU pattern depth; `SmuState` width is `$clog2(N)`.
- `HOLD_W`, 8: width of the hold-cycle register and the internal down-counter.
- `CNT_W`, 16: width of the saturating trigger counter.
---
- `gated_clk`, in, 1: block clock, same gated clock domain as the SMU.
- `reset`, in, 1: synchronous, active-high.
- `trigger`, in, 1: SMU match pulse. It is sampled every cycle.
- `SmuState`, in, `$clog2(N)`: SMU state. It is captured into the event record.
- `RegMode`, in, 2: 00 disabled, 01 retriggerable hold, 10 sticky, 11 one-shot.
- `RegHoldCycles`, in, `HOLD_W`: override length minus one.
- `RegClear`, in, 1: pulse. It returns the block to IDLE, zeroes `trig_count` and clears the event and overflow flags.
- `ctrl_en`, out, 1: override enable to the signal control stage. It is registered.
- `busy`, out, 1: high when the FSM is not in IDLE.
- `trig_count`, out, `CNT_W`: number of accepted triggers. It saturates at all-ones.
- `evt_valid`, out, 1: event pending.
- `evt_ack`, in, 1: consumer acknowledge.
- `evt_state`, out, `$clog2(N)`: `SmuState` captured at the accepted trigger.
- `evt_overflow`, out, 1: sticky flag. It is set when an event is lost.

## Operation
- FSM states: IDLE, HOLD, STICKY, DONE. There is an internal down-counter `hold_cnt[HOLD_W-1:0]`.
- Priority order: `reset` > `RegClear` > `RegMode==00` > trigger handling.
- Reset or `RegClear` puts the block in this state: FSM=IDLE, `hold_cnt`=0, `ctrl_en`=0, `trig_count`=0, `evt_valid`=0, `evt_state`=0, `evt_overflow`=0.
- `RegMode==00`:
  - From any state, go to IDLE next cycle with `ctrl_en`=0.
  - Triggers are not accepted and not counted.
- Accepted trigger (`trigger`=1, mode≠00, and not in DONE):
  - Increment `trig_count`, saturating.
  - Post an event.
- IDLE + accepted trigger:
  - mode 01 or 11: go to HOLD, load `hold_cnt`=`RegHoldCycles`.
  - mode 10: go to STICKY.
  - `RegMode` is sampled only here. Later mode changes (other than to 00) do not alter the current HOLD or STICKY episode.
- HOLD (`ctrl_en`=1):
  - If `hold_cnt`==0 and no reload: go to IDLE if the episode started in mode 01, or to DONE if it started in mode 11.
  - Otherwise decrement `hold_cnt`.
  - Episode mode 01 + trigger: reload `hold_cnt`=`RegHoldCycles` (retrigger). The trigger is counted and posted.
  - Episode mode 11 + trigger: ignored. Not counted, no event posted.
- STICKY (`ctrl_en`=1): stay until `RegClear` or mode 00. Further triggers are counted and posted.
- DONE (`ctrl_en`=0): triggers are ignored until `RegClear`.
- Event post rules:
  - `evt_valid`=0: set `evt_valid`, capture `evt_state`.
  - `evt_valid`=1 and `evt_ack`=1 in the same cycle: `evt_valid` stays 1, `evt_state` takes the new value, no overflow.
  - `evt_valid`=1 and no ack: `evt_state` is kept (oldest wins) and `evt_overflow` is set.
- `evt_ack` with no new post clears `evt_valid` next cycle. `evt_ack` while `evt_valid`=0 is ignored.

## Timing
- All outputs are registered and update on the `gated_clk` rising edge.
- Trigger accepted in cycle t:
  - `trig_count`, `evt_valid` and `evt_state` update in t+1.
  - `ctrl_en` rises in t+1.
- HOLD with no retrigger: `ctrl_en` is high for exactly `RegHoldCycles`+1 cycles. `RegHoldCycles`=0 gives a 1-cycle pulse.
- A retrigger in cycle t extends `ctrl_en` through t+1+`RegHoldCycles`.
- `RegClear` or `reset` in cycle t: `ctrl_en`=0 in t+1. A trigger in the same cycle is discarded.
- While `gated_clk` is stopped (SMU disabled), all state holds. The block needs no extra enable.
- Counter wrap: at `trig_count`==2^CNT_W−1 it holds its value. Events are still posted.

## Test plan
- **Retriggerable hold, no retrigger.**
  - Stimulus: reset; mode=01, Hold=3; trigger at cycle 10.
  - Required: `ctrl_en` high cycles 11–14; `trig_count`=1; `evt_valid`=1 from cycle 11.
- **Retrigger extension.**
  - Stimulus: mode=01, Hold=3; triggers at cycles 10 and 12.
  - Required: `ctrl_en` high cycles 11–16; `trig_count`=2; `evt_overflow`=1 (no ack given); `evt_state` holds the cycle-10 `SmuState`.
- **One-shot.**
  - Stimulus: mode=11, Hold=0; triggers at cycles 5, 6 and 9.
  - Required: `ctrl_en` high in cycle 6 only; state DONE; `trig_count`=1; then `RegClear` gives IDLE and `trig_count`=0.
- **Sticky and mode disable.**
  - Stimulus: mode=10; trigger; `ctrl_en` stays high for 100 cycles; then mode=00.
  - Required: `ctrl_en`=0 the next cycle; later triggers are not counted.
- **Handshake.**
  - Stimulus: `evt_valid`=1 with `evt_ack`=1 and a trigger (`SmuState`=1) in the same cycle.
  - Required: `evt_valid` stays 1, `evt_state`=1, `evt_overflow`=0; a later ack alone gives `evt_valid`=0.
- **Saturation and reset mid-hold.**
  - Stimulus: CNT_W=2; 5 triggers; then `reset` during HOLD.
  - Required: `trig_count` sticks at 3; after reset all outputs are 0 next cycle.
